// File: rtl/vx_stream_burst_arb.sv
// vx_stream_burst_arb: round-robin N-to-1 stream arbiter with bounded burst locking and a 2-entry registered output buffer
module vx_stream_burst_arb #(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = 32,
    parameter int MAX_BURST = 4,
    parameter int SELW      = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                valid_in,
    output logic [NUM_REQS-1:0]                ready_in,
    input  logic [NUM_REQS-1:0][DATAW-1:0]     data_in,
    output logic                               valid_out,
    input  logic                               ready_out,
    output logic [DATAW-1:0]                   data_out,
    output logic [SELW-1:0]                    sel_out
);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [SELW-1:0]  last_idx, pick, tail_sel;
    logic [CW-1:0]    burst_cnt;
    logic [DATAW-1:0] tail_data;
    logic [1:0]       count;
    logic             pick_valid, push, pop;

    // Keep the burst owner while it is valid, else scan circularly after the last grant (nearest index wins)
    always_comb begin
        pick_valid = 1'b0;
        pick       = last_idx;
        if (burst_cnt != '0 && valid_in[last_idx])
            pick_valid = 1'b1;
        else
            for (int k = NUM_REQS; k >= 1; k--)
                if (valid_in[(int'(last_idx) + k) % NUM_REQS]) begin
                    pick_valid = 1'b1;
                    pick       = SELW'((int'(last_idx) + k) % NUM_REQS);
                end
    end

    // Accept only into a non-full buffer so ready_in never looks at ready_out
    always_comb begin
        ready_in       = '0;
        ready_in[pick] = pick_valid && count != 2'd2;
    end

    assign push      = pick_valid && count != 2'd2;
    assign pop       = valid_out && ready_out;
    assign valid_out = count != 2'd0;

    // Track the last grant and how many beats of its burst have gone through
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_idx  <= SELW'(NUM_REQS - 1);
            burst_cnt <= '0;
        end else if (push) begin
            last_idx <= pick;
            if (pick == last_idx && burst_cnt != '0)
                burst_cnt <= (burst_cnt + CW'(1) == CW'(MAX_BURST)) ? '0 : burst_cnt + CW'(1);
            else
                burst_cnt <= (MAX_BURST == 1) ? '0 : CW'(1);
        end
    end

    // Two-entry buffer: the head registers drive the outputs directly, the tail catches the second beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            sel_out   <= '0;
            data_out  <= '0;
            tail_sel  <= '0;
            tail_data <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (push && (count == 2'd0 || pop)) begin
                sel_out  <= pick;
                data_out <= data_in[pick];
            end else if (pop) begin
                sel_out  <= tail_sel;
                data_out <= tail_data;
            end
            if (push) begin
                tail_sel  <= pick;
                tail_data <= data_in[pick];
            end
        end
    end
endmodule
